serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1 to 32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN).
REQ-009 Port: done  output  1  one-cycle pulse when sum/cout are updated.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Port: cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL add bit-serially, LSB first, one bit per clock, through a single full-adder cell and one carry flip-flop.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on a clk edge with start=1: load a and b into shift registers, load cin into the carry FF, clear the bit counter, set busy=1.
REQ-015 Each RUN edge SHALL add shA[0] + shB[0] + carry, shift the sum bit into the MSB of the working result register, shift shA/shB right by one, load the carry FF with the cell carry, and increment the counter.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1, which is edge N+WIDTH when start was accepted at edge N.
REQ-017 On that same edge, sum SHALL be loaded with the complete working result, cout with the final carry, busy SHALL clear, and done SHALL be set.
REQ-018 DONE -> IDLE SHALL occur unconditionally on the next edge; done is high for exactly one cycle.
REQ-019 The earliest next start accepted after acceptance at edge N is at edge N+WIDTH+2.
REQ-020 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-021 a, b and cin SHALL be don't-care outside the accepting edge; changes during RUN SHALL NOT affect the result.
REQ-022 sum and cout SHALL hold their previous values throughout RUN and change only on the DONE-entry edge.
REQ-023 Arithmetic: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-025 If start is held high continuously, an operation SHALL begin every WIDTH+2 cycles.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the shift registers, carry FF and counter.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-028 The first start after rst deasserts SHALL be accepted on the first clk edge with rst=0 and start=1.

Structure
REQ-029 A shared package serial_adder_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 The per-bit adder SHALL be one instance of the team's existing full_adder, port order (A, B, Cin, Sum, Cout).
REQ-031 No other sub-modules SHALL be used; the FSM, shift registers, counter and output registers are local.

Verification (WIDTH=8)
REQ-032 Zero case: a=00, b=00, cin=0 -> sum=00, cout=0; done exactly 8 cycles after the accepting edge; busy high for 8 cycles.
REQ-033 Full ripple: a=FF, b=01, cin=0 -> sum=00, cout=1.
REQ-034 Carry-in and complementary operands: a=A5, b=5A, cin=1 -> sum=00, cout=1.
REQ-035 Start ignored and inputs insensitive: start with a=3C, b=42, cin=0; at RUN cycle 3 drive start=1, a=FF, b=FF -> sum=7E, cout=0, single done pulse.
REQ-036 Reset mid-run: start a=12, b=34; assert rst at RUN cycle 4 -> busy=0, sum=00, cout=0, no done; then a=80, b=80, cin=0 -> sum=00, cout=1.
REQ-037 Back-to-back: start held high with a=01, b=01 -> done pulses exactly 10 cycles apart, each with sum=02, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial adder's arithmetic core.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full-adder
// cell and one carry flip-flop. The result is published with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB; concatenating first keeps this legal for WIDTH=1.
  assign res_cat  = {fa_sum, res};
  assign res_next = res_cat[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            res   <= '0;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_cout;
          res   <= res_next;
          cnt   <= cnt + CNT_W'(1);
          // Outputs only move on the edge that retires the final bit.
          if (last_bit) begin
            sum  <= res_next;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) using a result scoreboard queue.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  logic [W:0] sb_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive an accepted request: inputs set now, accepting edge is the next posedge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin);
    logic [W:0] exp;
    exp = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
    sb_q.push_back(exp);
    a = ia; b = ib; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; reports edges taken, busy samples and whether outputs held.
  task automatic wait_done(input int budget, output int edges, output int busy_cnt,
                           output bit timed_out, output bit held);
    logic [W:0] prev;
    prev = {cout, sum};
    edges = 0; busy_cnt = busy ? 1 : 0; timed_out = 1'b1; held = 1'b1;
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if ({cout, sum} !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%h required 0 0 0 00", busy, done, cout, sum);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int e, bc; bit to, h;
    logic [W:0] exp;
    issue(8'h00, 8'h00, 1'b0);
    wait_done(40, e, bc, to, h);
    checks++;
    if (to) begin
      errors++; $display("FAIL zero_timeout: no done within 40 edges");
    end
    exp = sb_q.pop_front();
    checks++;
    if ({cout, sum} !== exp) begin
      errors++; $display("FAIL zero_result: got %b_%h required %b_%h", cout, sum, exp[W], exp[W-1:0]);
    end
    checks++;
    if (e !== W) begin
      errors++; $display("FAIL zero_latency: done after %0d edges required %0d", e, W);
    end
    checks++;
    if (bc !== W) begin
      errors++; $display("FAIL zero_busy_len: busy %0d cycles required %0d", bc, W);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL zero_done_width: done=%b one cycle later required 0", done);
    end
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic icin, input logic [W:0] required);
    int e, bc; bit to, h;
    logic [W:0] exp;
    issue(ia, ib, icin);
    wait_done(40, e, bc, to, h);
    exp = sb_q.pop_front();
    checks++;
    if (to || {cout, sum} !== exp || exp !== required) begin
      errors++;
      $display("FAIL %s: got %b_%h timeout=%b required %b_%h", name, cout, sum, to, required[W], required[W-1:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int e, bc, extra; bit to, h;
    logic [W:0] exp;
    issue(8'h3C, 8'h42, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    wait_done(40, e, bc, to, h);
    start = 1'b0;
    exp = sb_q.pop_front();
    checks++;
    if (to || {cout, sum} !== exp || exp !== 9'h07E) begin
      errors++; $display("FAIL ignore_result: got %b_%h timeout=%b required 0_7e", cout, sum, to);
    end
    checks++;
    if (!h) begin
      errors++; $display("FAIL ignore_hold: sum/cout changed during run, required stable");
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_queued: %0d busy/done cycles after op required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int e, bc, stray; bit to, h;
    logic [W:0] exp;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%h required 0 0 0 00", busy, done, cout, sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL abort_no_done: %0d busy/done cycles after abort required 0", stray);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    issue(8'h80, 8'h80, 1'b0);
    wait_done(40, e, bc, to, h);
    exp = sb_q.pop_front();
    checks++;
    if (to || {cout, sum} !== exp || exp !== 9'h100) begin
      errors++; $display("FAIL post_reset_result: got %b_%h timeout=%b required 1_00", cout, sum, to);
    end
    checks++;
    if (e !== W) begin
      errors++; $display("FAIL post_reset_latency: done after %0d edges required %0d", e, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t, n;
    int when[3];
    logic [W:0] exp;
    repeat (3) sb_q.push_back(9'h002);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    t = 0; n = 0;
    while (t < 80 && n < 3) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        when[n] = t;
        exp = sb_q.pop_front();
        checks++;
        if ({cout, sum} !== exp) begin
          errors++; $display("FAIL b2b_result%0d: got %b_%h required 0_02", n, cout, sum);
        end
        n++;
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count: %0d done pulses required 3", n);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (when[i] - when[i-1] !== W + 2) begin
          errors++; $display("FAIL b2b_spacing%0d: %0d cycles required %0d", i, when[i] - when[i-1], W + 2);
        end
      end
    end
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int e, bc; bit to, h;
    logic [W:0] exp;
    logic [W-1:0] ra, rb;
    logic rc;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      issue(ra, rb, rc);
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      wait_done(40, e, bc, to, h);
      exp = sb_q.pop_front();
      checks++;
      if (to || {cout, sum} !== exp || e !== W - 1 || !h) begin
        errors++;
        $display("FAIL random%0d: %h+%h+%b got %b_%h edges=%0d held=%b required %b_%h",
                 i, ra, rb, rc, cout, sum, e + 1, h, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vector("full_ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
    test_vector("cin_complement", 8'hA5, 8'h5A, 1'b1, 9'h100);
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
